// File: rtl/ctrl_pipe_n.sv
// Parametrised control-word pipeline from decode through STAGES downstream stages.
// Per-stage valid/invalid tracking, bubble insertion on partial stalls, exception tap and occupancy count.
module ctrl_pipe_n #(
    parameter int W         = 14,
    parameter int STAGES    = 3,
    parameter int EXC_STAGE = 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [W-1:0]                   sigs_d,
    input  logic                           valid_d,
    input  logic                           invalid_d,
    input  logic                           stall_d,
    input  logic [STAGES-1:0]              stall,
    input  logic [STAGES-1:0]              flush,
    output logic [W*STAGES-1:0]            sigs_q,
    output logic [STAGES-1:0]              valid_q,
    output logic                           exc_o,
    output logic [$clog2(STAGES+1)-1:0]    inflight
);

    localparam int CW = $clog2(STAGES + 1);

    generate
        if (STAGES < 1 || EXC_STAGE < 0 || EXC_STAGE >= STAGES) begin : g_param_chk
            $error("ctrl_pipe_n: requires STAGES >= 1 and 0 <= EXC_STAGE < STAGES");
        end
    endgenerate

    logic [W-1:0]      word_q [STAGES];
    logic [W-1:0]      word_d [STAGES];
    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] inv_q, inv_d;

    logic [W-1:0]      up_word [STAGES];
    logic [STAGES-1:0] up_vld, up_inv, up_stall;

    // An invalid flag only means something when it rides on a real instruction.
    always_comb begin
        up_word[0]  = sigs_d;
        up_vld[0]   = valid_d;
        up_inv[0]   = invalid_d & valid_d;
        up_stall[0] = stall_d;
        for (int s = 1; s < STAGES; s++) begin
            up_word[s]  = word_q[s-1];
            up_vld[s]   = vld_q[s-1];
            up_inv[s]   = inv_q[s-1];
            up_stall[s] = stall[s-1];
        end
    end

    always_comb begin
        vld_d = '0;
        inv_d = '0;
        for (int s = 0; s < STAGES; s++) begin
            word_d[s] = '0;
            if (flush[s]) begin
                word_d[s] = '0;
            end else if (stall[s]) begin
                word_d[s] = word_q[s];
                vld_d[s]  = vld_q[s];
                inv_d[s]  = inv_q[s];
            end else if (up_stall[s]) begin
                // Upstream entry is held, so this stage takes a bubble rather than a copy.
                word_d[s] = '0;
            end else begin
                word_d[s] = up_word[s];
                vld_d[s]  = up_vld[s];
                inv_d[s]  = up_inv[s];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int s = 0; s < STAGES; s++) word_q[s] <= '0;
            vld_q <= '0;
            inv_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) word_q[s] <= word_d[s];
            vld_q <= vld_d;
            inv_q <= inv_d;
        end
    end

    always_comb begin
        sigs_q   = '0;
        inflight = '0;
        for (int s = 0; s < STAGES; s++) begin
            sigs_q[s*W +: W] = word_q[s];
            inflight         = inflight + CW'(vld_q[s]);
        end
    end

    assign valid_q = vld_q;
    assign exc_o   = vld_q[EXC_STAGE] & inv_q[EXC_STAGE];

endmodule
